oh_pads_seq: RTL and testbench



---
 rtl/oh_pads_pkg.sv | 23 ++
 rtl/oh_dsync.sv | 34 +++
 rtl/oh_pads_seq.sv | 155 +++++++++++++++
 tb/tb_oh_pads_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/oh_pads_pkg.sv
// ============================================================================
//  Module  : oh_pads_pkg
//  Purpose : Shared types and default timing constants for the padring control.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package oh_pads_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_UP    = 3'd1,
    ST_ON    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_FAULT = 3'd4
  } pads_state_t;

  localparam int c_DEF_DELAY    = 16;
  localparam int c_DEF_SYNCPIPE = 2;

endpackage : oh_pads_pkg

`default_nettype wire

// File: rtl/oh_dsync.sv
// ============================================================================
//  Module  : oh_dsync
//  Purpose : SYNCPIPE-deep single-bit synchroniser with active-low sync reset.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module oh_dsync #(
  parameter int SYNCPIPE = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_din,
  output logic o_dout
);

  logic [SYNCPIPE-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < SYNCPIPE; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_dout = r_pipe[SYNCPIPE-1];

endmodule : oh_dsync

`default_nettype wire

// File: rtl/oh_pads_seq.sv
// ============================================================================
//  Module  : oh_pads_seq
//  Purpose : Staged pad-bank power sequencer with supply-loss shutdown.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module oh_pads_seq
  import oh_pads_pkg::*;
#(
  parameter int NBANKS   = 4,
  parameter int DELAY    = c_DEF_DELAY,
  parameter int SYNCPIPE = c_DEF_SYNCPIPE,
  parameter int CW       = $clog2(DELAY + 1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              pwr_ok,
  input  logic              on_req,
  output logic [NBANKS-1:0] bank_en,
  output logic              done,
  output logic              busy,
  output logic              fault
);

  localparam int             IW     = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [IW-1:0]  c_LAST = IW'(NBANKS - 1);
  localparam logic [IW-1:0]  c_IONE = IW'(1);
  localparam logic [CW-1:0]  c_CMAX = CW'(DELAY - 1);
  localparam logic [CW-1:0]  c_CONE = CW'(1);

  logic              w_pwr_ok_s;
  pads_state_t       r_state;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [NBANKS-1:0] r_bank_en;
  logic              r_done;
  logic              r_busy;
  logic              r_fault;

  oh_dsync #(
    .SYNCPIPE (SYNCPIPE)
  ) u_pwr_sync (
    .clk    (clk),
    .nreset (nreset),
    .i_din  (pwr_ok),
    .o_dout (w_pwr_ok_s)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state   <= ST_OFF;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_bank_en <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
    end else if (!w_pwr_ok_s &&
                 (r_state == ST_UP || r_state == ST_ON || r_state == ST_DOWN)) begin
      // Supply loss drops every bank at once, bypassing the staged ramp.
      r_state   <= ST_FAULT;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_bank_en <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b1;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (on_req && w_pwr_ok_s) begin
            r_state <= ST_UP;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_UP: begin
          if (!on_req) begin
            // Abort wins over a same-edge step; ramp down from the top enabled bank.
            r_cnt <= '0;
            if (r_idx == '0) begin
              r_state <= ST_OFF;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DOWN;
              r_idx   <= r_idx - c_IONE;
            end
          end else if (r_cnt == c_CMAX) begin
            r_bank_en[r_idx] <= 1'b1;
            r_cnt            <= '0;
            if (r_idx == c_LAST) begin
              r_state <= ST_ON;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + c_IONE;
            end
          end else begin
            r_cnt <= r_cnt + c_CONE;
          end
        end
        ST_ON: begin
          if (!on_req) begin
            r_state <= ST_DOWN;
            r_idx   <= c_LAST;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_DOWN: begin
          if (r_cnt == c_CMAX) begin
            r_bank_en[r_idx] <= 1'b0;
            r_cnt            <= '0;
            if (r_idx == '0) begin
              r_state <= ST_OFF;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx - c_IONE;
            end
          end else begin
            r_cnt <= r_cnt + c_CONE;
          end
        end
        ST_FAULT: begin
          r_bank_en <= '0;
          // Software acknowledges by dropping on_req once supplies are back.
          if (w_pwr_ok_s && !on_req) begin
            r_state <= ST_OFF;
            r_fault <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_OFF;
          r_idx     <= '0;
          r_cnt     <= '0;
          r_bank_en <= '0;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_fault   <= 1'b0;
        end
      endcase
    end
  end

  assign bank_en = r_bank_en;
  assign done    = r_done;
  assign busy    = r_busy;
  assign fault   = r_fault;

endmodule : oh_pads_seq

`default_nettype wire

// File: tb/tb_oh_pads_seq.sv
// ============================================================================
//  Module  : tb_oh_pads_seq
//  Purpose : Self-checking bench for oh_pads_seq across three parameter sets.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_oh_pads_seq;

  localparam int NDUT    = 3;
  localparam int M_OFF   = 0;
  localparam int M_UP    = 1;
  localparam int M_ON    = 2;
  localparam int M_DOWN  = 3;
  localparam int M_FAULT = 4;
  localparam int NPIN    = 18;
  localparam int NCYC    = 4000;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       pwr_ok = 1'b0;
  logic       on_req = 1'b0;

  logic [3:0] be0;
  logic [0:0] be1;
  logic [7:0] be2;
  logic [2:0] dn, bs, ft;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Model state: mode, number of banks lit, edge of the next bank change, sync history.
  int mode  [NDUT];
  int nlit  [NDUT];
  int tnext [NDUT];
  bit sh    [NDUT][8];

  int         pin_e  [NPIN] = '{2, 12, 13, 16, 19, 21, 22, 33, 36, 39, 42, 63, 66, 67, 86, 87, 94, 95};
  logic [3:0] pin_be [NPIN] = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0111, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                                4'b1111, 4'b0000, 4'b0000, 4'b0000};
  // {done,busy,fault}
  logic [2:0] pin_fl [NPIN] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100,
                                3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000,
                                3'b100, 3'b001, 3'b001, 3'b000};

  always #5 clk = ~clk;

  oh_pads_seq #(.NBANKS(4), .DELAY(3), .SYNCPIPE(2)) u_dut0 (
    .clk(clk), .nreset(nreset), .pwr_ok(pwr_ok), .on_req(on_req),
    .bank_en(be0), .done(dn[0]), .busy(bs[0]), .fault(ft[0]));

  oh_pads_seq #(.NBANKS(1), .DELAY(1), .SYNCPIPE(2)) u_dut1 (
    .clk(clk), .nreset(nreset), .pwr_ok(pwr_ok), .on_req(on_req),
    .bank_en(be1), .done(dn[1]), .busy(bs[1]), .fault(ft[1]));

  oh_pads_seq #(.NBANKS(8), .DELAY(1), .SYNCPIPE(1)) u_dut2 (
    .clk(clk), .nreset(nreset), .pwr_ok(pwr_ok), .on_req(on_req),
    .bank_en(be2), .done(dn[2]), .busy(bs[2]), .fault(ft[2]));

  function automatic int nb_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 8;
  endfunction

  function automatic int dl_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int sp_of(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic logic [7:0] act_be(input int k);
    return (k == 0) ? {4'b0, be0} : (k == 1) ? {7'b0, be1} : be2;
  endfunction

  task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d edge %0d: got %b expected %b", name, k, edge_n, act, exp);
    end
  endtask

  task automatic model_edge(input int k, input bit rst_n, input bit on, input bit pok);
    bit ps;
    if (!rst_n) begin
      mode[k] = M_OFF;
      nlit[k] = 0;
      for (int i = 0; i < 8; i++) sh[k][i] = 1'b0;
    end else begin
      ps = sh[k][0];
      for (int i = 0; i < sp_of(k) - 1; i++) sh[k][i] = sh[k][i+1];
      sh[k][sp_of(k)-1] = pok;
      if (!ps && (mode[k] == M_UP || mode[k] == M_ON || mode[k] == M_DOWN)) begin
        mode[k] = M_FAULT;
        nlit[k] = 0;
      end else begin
        case (mode[k])
          M_OFF: if (on && ps) begin
            mode[k]  = M_UP;
            tnext[k] = edge_n + dl_of(k);
          end
          M_UP: begin
            if (!on) begin
              if (nlit[k] == 0) mode[k] = M_OFF;
              else begin
                mode[k]  = M_DOWN;
                tnext[k] = edge_n + dl_of(k);
              end
            end else if (edge_n == tnext[k]) begin
              nlit[k]++;
              if (nlit[k] == nb_of(k)) mode[k] = M_ON;
              else tnext[k] = edge_n + dl_of(k);
            end
          end
          M_ON: if (!on) begin
            mode[k]  = M_DOWN;
            tnext[k] = edge_n + dl_of(k);
          end
          M_DOWN: if (edge_n == tnext[k]) begin
            nlit[k]--;
            if (nlit[k] == 0) mode[k] = M_OFF;
            else tnext[k] = edge_n + dl_of(k);
          end
          default: if (ps && !on) mode[k] = M_OFF;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] b;
    for (int k = 0; k < NDUT; k++) begin
      b = act_be(k);
      check("bank_en", k, b, 8'(((1 << nlit[k]) - 1)));
      check("thermometer", k, {7'b0, ((b + 8'd1) & b) == 8'd0}, 8'd1);
      check("flags", k, {5'b0, dn[k], bs[k], ft[k]},
            {5'b0, mode[k] == M_ON, mode[k] == M_UP || mode[k] == M_DOWN, mode[k] == M_FAULT});
    end
  endtask

  initial begin
    int pin_i = 0;
    bit r_on = 1'b0, r_pok = 1'b1, r_rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      mode[k] = M_OFF; nlit[k] = 0; tnext[k] = 0;
      for (int i = 0; i < 8; i++) sh[k][i] = 1'b0;
    end
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      if (c <= 100) begin
        r_rst = !(c <= 2 || c == 50);
        r_pok = !(c >= 85 && c <= 88);
        r_on  = (c >= 10 && c <= 29) || (c >= 60 && c <= 63) || (c >= 70 && c < 95);
      end else begin
        if ($urandom_range(0, 24) == 0) r_on = ~r_on;
        if (r_pok) r_pok = ($urandom_range(0, 299) != 0);
        else       r_pok = ($urandom_range(0, 7) == 0);
        r_rst = ($urandom_range(0, 399) != 0);
      end
      nreset = r_rst;
      pwr_ok = r_pok;
      on_req = r_on;
      @(posedge clk);
      edge_n = c;
      for (int k = 0; k < NDUT; k++) model_edge(k, r_rst, r_on, r_pok);
      #1;
      compare_all();
      if (pin_i < NPIN && edge_n == pin_e[pin_i]) begin
        check("pin_bank_en", 0, {4'b0, be0}, {4'b0, pin_be[pin_i]});
        check("pin_flags", 0, {5'b0, dn[0], bs[0], ft[0]}, {5'b0, pin_fl[pin_i]});
        pin_i++;
      end
    end
    if (pin_i != NPIN) begin
      bad++;
      $display("FAIL pin_coverage: reached %0d pins, required %0d", pin_i, NPIN);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_oh_pads_seq

`default_nettype wire
